// File: rtl/tx_data_framer.sv
// 802.11a DATA-field framer: SERVICE, PSDU, tail and pad bits, scrambled with x^7+x^4+1.
// The pad count is derived from symbol-counter wraps, so no divider is needed.
module tx_data_framer #(
  parameter int unsigned LEN_W        = 12,
  parameter int unsigned SERVICE_BITS = 16,
  parameter int unsigned TAIL_BITS    = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       Rate,
  input  logic [LEN_W-1:0] Length,
  input  logic [6:0]       Seed,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sym_start,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             rate_err,
  output logic [8:0]       num_pads
);

  localparam int unsigned FLD_W0 = LEN_W + 3;
  localparam int unsigned FLD_W  = (FLD_W0 > 8) ? FLD_W0 : 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SERVICE,
    S_PSDU,
    S_TAIL,
    S_PAD
  } state_e;

  state_e           state_q;
  logic [6:0]       scr_q;
  logic [6:0]       scr_d;
  logic [FLD_W-1:0] fld_cnt_q;
  logic [7:0]       sym_cnt_q;
  logic [7:0]       ndbps_q;
  logic [LEN_W-1:0] len_q;
  logic             done_q;
  logic             rate_err_q;
  logic [8:0]       num_pads_q;

  logic             fb_c;
  logic             data_c;
  logic             out_valid_c;
  logic             in_ready_c;
  logic             xfer_c;
  logic             sym_wrap_c;
  logic             fld_last_c;
  logic [FLD_W-1:0] psdu_bits_c;

  // Data bits per OFDM symbol for each RATE code; 0 flags an unsupported code.
  function automatic logic [7:0] rate_ndbps(input logic [3:0] r);
    logic [7:0] n;
    case (r)
      4'b1101: n = 8'd24;
      4'b1111: n = 8'd36;
      4'b0101: n = 8'd48;
      4'b0111: n = 8'd72;
      4'b1001: n = 8'd96;
      4'b1011: n = 8'd144;
      4'b0001: n = 8'd192;
      4'b0011: n = 8'd216;
      default: n = 8'd0;
    endcase
    return n;
  endfunction

  assign fb_c        = scr_q[6] ^ scr_q[3];
  assign scr_d       = {scr_q[5:0], fb_c};
  assign psdu_bits_c = FLD_W'({len_q, 3'b000});
  assign sym_wrap_c  = (sym_cnt_q == 8'(ndbps_q - 8'd1));

  // Handshake and data source for the current field.
  always_comb begin
    out_valid_c = 1'b0;
    in_ready_c  = 1'b0;
    data_c      = 1'b0;
    fld_last_c  = 1'b0;
    case (state_q)
      S_SERVICE: begin
        out_valid_c = 1'b1;
        fld_last_c  = (fld_cnt_q == FLD_W'(SERVICE_BITS - 1));
      end
      S_PSDU: begin
        out_valid_c = in_valid;
        in_ready_c  = out_ready;
        data_c      = in_bit;
        fld_last_c  = (fld_cnt_q == psdu_bits_c - FLD_W'(1));
      end
      S_TAIL: begin
        out_valid_c = 1'b1;
        fld_last_c  = (fld_cnt_q == FLD_W'(TAIL_BITS - 1));
      end
      S_PAD: begin
        out_valid_c = 1'b1;
      end
      default: ;
    endcase
  end

  assign xfer_c = out_valid_c && out_ready;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      scr_q      <= 7'h7F;
      fld_cnt_q  <= '0;
      sym_cnt_q  <= '0;
      ndbps_q    <= '0;
      len_q      <= '0;
      done_q     <= 1'b0;
      rate_err_q <= 1'b0;
      num_pads_q <= '0;
    end else begin
      done_q     <= 1'b0;
      rate_err_q <= 1'b0;
      if (state_q == S_IDLE) begin
        if (Start) begin
          if (rate_ndbps(Rate) == 8'd0) begin
            rate_err_q <= 1'b1;
          end else begin
            ndbps_q   <= rate_ndbps(Rate);
            len_q     <= Length;
            scr_q     <= (Seed == 7'd0) ? 7'h7F : Seed;
            fld_cnt_q <= '0;
            sym_cnt_q <= '0;
            state_q   <= S_SERVICE;
          end
        end
      end else if (xfer_c) begin
        scr_q     <= scr_d;
        sym_cnt_q <= sym_wrap_c ? 8'd0 : 8'(sym_cnt_q + 8'd1);
        fld_cnt_q <= fld_last_c ? '0 : FLD_W'(fld_cnt_q + FLD_W'(1));
        case (state_q)
          S_SERVICE: if (fld_last_c) state_q <= (len_q == '0) ? S_TAIL : S_PSDU;
          S_PSDU:    if (fld_last_c) state_q <= S_TAIL;
          S_TAIL: begin
            if (fld_last_c) begin
              // Bits still needed to close the current symbol.
              num_pads_q <= 9'(8'(ndbps_q - 8'd1 - sym_cnt_q));
              if (sym_wrap_c) begin
                state_q <= S_IDLE;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_PAD;
              end
            end
          end
          S_PAD: begin
            if (sym_wrap_c) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign in_ready      = in_ready_c;
  assign out_valid     = out_valid_c;
  assign out_bit       = (state_q == S_SERVICE || state_q == S_PSDU || state_q == S_PAD) ?
                         (data_c ^ fb_c) : 1'b0;
  assign out_sym_start = out_valid_c && (sym_cnt_q == 8'd0);
  assign out_last      = out_valid_c && sym_wrap_c &&
                         ((state_q == S_PAD) || (state_q == S_TAIL && fld_last_c));
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign rate_err      = rate_err_q;
  assign num_pads      = num_pads_q;

endmodule
